can_rx_crc: RTL and testbench

CAN_RX_CRC -- requirements
Module: can_rx_crc

---
 rtl/can_rx_crc_if.sv | 19 +
 rtl/can_rx_crc.sv | 99 +++++++++
 tb/tb_can_rx_crc.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_rx_crc_if.sv
// can_rx_crc_if: receive-side bundle of the CAN CRC receiver.
//   rx          serial line in (0 dominant, 1 recessive)
//   busy        frame in progress
//   frame_valid one-cycle completed-frame pulse
//   rx_id/rx_dlc/rx_data/rx_crc  decoded fields of the last frame
//   crc_err/form_err             error flags of the last frame
interface can_rx_crc_if;
    logic        rx;
    logic        busy;
    logic        frame_valid;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [7:0]  rx_data;
    logic [14:0] rx_crc;
    logic        crc_err;
    logic        form_err;
    modport master (output rx, input busy, frame_valid, rx_id, rx_dlc, rx_data, rx_crc, crc_err, form_err);
    modport slave  (input rx, output busy, frame_valid, rx_id, rx_dlc, rx_data, rx_crc, crc_err, form_err);
endinterface

// File: rtl/can_rx_crc.sv
// can_rx_crc: unstuffed CAN-like frame receiver with CRC-15 check.
//   clk    rising-edge clock, one line bit per cycle
//   rst_n  asynchronous active-low reset
//   bus    can_rx_crc_if.slave: rx in, decoded fields and status out
module can_rx_crc #(
    parameter logic [14:0] CRC_INIT = 15'h0000
) (
    input logic         clk,
    input logic         rst_n,
    can_rx_crc_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RX_ID, RX_DLC, RX_DATA, RX_CRC, CRC_DELIM, ACK_SLOT, EOF} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [14:0] crc;
    logic [14:0] crc_sr;
    logic [10:0] id_sr;
    logic [3:0]  dlc_sr;
    logic [7:0]  data_sr;
    logic        delim_err;
    logic        fb;
    logic [14:0] crc_next;
    always_comb begin
        fb       = crc[14] ^ bus.rx;
        crc_next = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    end
    // Fields are collected in private shift registers and copied to the
    // outputs only at the EOF bit, so partial frames never become visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            crc             <= '0;
            crc_sr          <= '0;
            id_sr           <= '0;
            dlc_sr          <= '0;
            data_sr         <= '0;
            delim_err       <= 1'b0;
            bus.busy        <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.rx_id       <= '0;
            bus.rx_dlc      <= '0;
            bus.rx_data     <= '0;
            bus.rx_crc      <= '0;
            bus.crc_err     <= 1'b0;
            bus.form_err    <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            case (state)
                IDLE: if (!bus.rx) begin
                    state    <= RX_ID;
                    cnt      <= 4'd10;
                    crc      <= CRC_INIT;
                    bus.busy <= 1'b1;
                end
                RX_ID: begin
                    id_sr <= {id_sr[9:0], bus.rx};
                    crc   <= crc_next;
                    state <= (cnt == 4'd0) ? RX_DLC : RX_ID;
                    cnt   <= (cnt == 4'd0) ? 4'd3 : cnt - 4'd1;
                end
                RX_DLC: begin
                    dlc_sr <= {dlc_sr[2:0], bus.rx};
                    crc    <= crc_next;
                    state  <= (cnt == 4'd0) ? RX_DATA : RX_DLC;
                    cnt    <= (cnt == 4'd0) ? 4'd7 : cnt - 4'd1;
                end
                RX_DATA: begin
                    data_sr <= {data_sr[6:0], bus.rx};
                    crc     <= crc_next;
                    state   <= (cnt == 4'd0) ? RX_CRC : RX_DATA;
                    cnt     <= (cnt == 4'd0) ? 4'd14 : cnt - 4'd1;
                end
                RX_CRC: begin
                    crc_sr <= {crc_sr[13:0], bus.rx};
                    state  <= (cnt == 4'd0) ? CRC_DELIM : RX_CRC;
                    cnt    <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                end
                CRC_DELIM: begin
                    delim_err <= ~bus.rx;
                    state     <= ACK_SLOT;
                end
                ACK_SLOT: state <= EOF;
                EOF: begin
                    state           <= IDLE;
                    bus.busy        <= 1'b0;
                    bus.frame_valid <= 1'b1;
                    bus.rx_id       <= id_sr;
                    bus.rx_dlc      <= dlc_sr;
                    bus.rx_data     <= data_sr;
                    bus.rx_crc      <= crc_sr;
                    bus.crc_err     <= crc_sr != crc;
                    bus.form_err    <= delim_err | ~bus.rx;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_can_rx_crc.sv
// tb_can_rx_crc: scoreboard bench for can_rx_crc frame decode, errors, reset and back-to-back timing.
module tb_can_rx_crc;
    typedef struct packed {
        logic [31:0] cyc;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [7:0]  data;
        logic [14:0] crc;
        logic        crc_err;
        logic        form_err;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    can_rx_crc_if bus();
    can_rx_crc #(.CRC_INIT(15'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    rec_t exp_q[$];
    rec_t got_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   low_cnt = 0;
    bit   arm = 1'b0;

    // cyc is the index of the edge just taken; outputs sampled 1 time unit later
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (arm && !bus.busy) low_cnt = low_cnt + 1;
        if (bus.frame_valid)
            got_q.push_back({cyc, bus.rx_id, bus.rx_dlc, bus.rx_data, bus.rx_crc, bus.crc_err, bus.form_err});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [14:0] crc_ref(input logic [22:0] b);
        logic [14:0] c;
        logic        f;
        c = 15'h0000;
        for (int i = 22; i >= 0; i--) begin
            f = c[14] ^ b[i];
            c = {c[13:0], 1'b0} ^ (f ? 15'h4599 : 15'h0000);
        end
        return c;
    endfunction

    function automatic logic [41:0] build(input logic [10:0] id, input logic [3:0] dlc, input logic [7:0] data,
                                          input logic [14:0] crc, input logic delim, input logic eof);
        return {1'b0, id, dlc, data, crc, delim, 1'b0, eof};
    endfunction

    // Drives a whole frame starting at the next negedge; its SOF is sampled as E0
    // and the expected record carries the cycle index of E41.
    task automatic send_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [7:0] data,
                              input bit flip, input logic delim, input logic eof);
        logic [14:0] rc;
        logic [41:0] f;
        rc = crc_ref({id, dlc, data}) ^ {14'b0, flip};
        f  = build(id, dlc, data, rc, delim, eof);
        for (int i = 41; i >= 0; i--) begin
            @(negedge clk);
            if (i == 41) exp_q.push_back({cyc + 42, id, dlc, data, rc, flip, ~delim | ~eof});
            bus.rx = f[i];
        end
    endtask

    task automatic test_reset;
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.frame_valid, bus.rx_id, bus.rx_dlc, bus.rx_data, bus.rx_crc, bus.crc_err, bus.form_err} !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b fv=%b id=%h dlc=%h data=%h crc=%h ce=%b fe=%b, expected all 0",
                     bus.busy, bus.frame_valid, bus.rx_id, bus.rx_dlc, bus.rx_data, bus.rx_crc, bus.crc_err, bus.form_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle;
        low_cnt = 0;
        arm = 1'b1;
        repeat (100) @(negedge clk);
        arm = 1'b0;
        checks++;
        if (low_cnt !== 100) begin
            failures++;
            $display("FAIL idle_busy: busy low in %0d of 100 cycles, expected 100", low_cnt);
        end
        checks++;
        if (got_q.size() !== 0) begin
            failures++;
            $display("FAIL idle_frame_valid: %0d pulses, expected 0", got_q.size());
        end
    endtask

    task automatic test_all_zero;
        rec_t g, e;
        send_frame(11'h000, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        bus.rx = 1'b1;
        checks++;
        if ({bus.frame_valid, bus.busy} !== 2'b10) begin
            failures++;
            $display("FAIL zero_e41_status: fv=%b busy=%b, expected fv=1 busy=0", bus.frame_valid, bus.busy);
        end
        e = exp_q.pop_front();
        checks++;
        if (got_q.size() == 0) begin
            failures++;
            $display("FAIL zero_frame: no frame seen, expected %h", e);
        end else begin
            g = got_q.pop_front();
            if (g !== e) begin
                failures++;
                $display("FAIL zero_frame: got %h expected %h", g, e);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse_width: fv=%b one cycle after E41, expected 0", bus.frame_valid);
        end
    endtask

    task automatic test_crc;
        rec_t g, e;
        for (int k = 0; k < 2; k++) begin
            send_frame(11'h123, 4'h8, 8'hA5, k[0], 1'b1, 1'b1);
            @(negedge clk);
            bus.rx = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL crc_frame%0d: no frame seen, expected %h", k, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL crc_frame%0d: got %h expected %h", k, g, e);
                end
            end
            repeat (2) @(negedge clk);
            checks++;
            if ({bus.rx_id, bus.rx_dlc, bus.rx_data, bus.crc_err} !== {11'h123, 4'h8, 8'hA5, k[0]}) begin
                failures++;
                $display("FAIL crc_hold%0d: id=%h dlc=%h data=%h ce=%b, expected 123 8 a5 %b",
                         k, bus.rx_id, bus.rx_dlc, bus.rx_data, bus.crc_err, k[0]);
            end
        end
    endtask

    task automatic test_form;
        rec_t g, e;
        for (int k = 0; k < 2; k++) begin
            send_frame(11'h5A3, 4'h3, 8'h3C, 1'b0, k[0], ~k[0]);
            @(negedge clk);
            bus.rx = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL form_frame%0d: no frame seen, expected %h", k, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL form_frame%0d: got %h expected %h", k, g, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        rec_t g1, g2, e;
        low_cnt = 0;
        send_frame(11'h7FF, 4'hF, 8'hFF, 1'b0, 1'b1, 1'b1);
        arm = 1'b1;
        send_frame(11'h001, 4'h1, 8'h80, 1'b0, 1'b1, 1'b1);
        arm = 1'b0;
        @(negedge clk);
        bus.rx = 1'b1;
        checks++;
        if (got_q.size() < 2) begin
            failures++;
            $display("FAIL b2b_count: %0d frames seen, expected 2", got_q.size());
            got_q.delete();
            exp_q.delete();
        end else begin
            g1 = got_q.pop_front();
            e  = exp_q.pop_front();
            if (g1 !== e) begin
                failures++;
                $display("FAIL b2b_frame1: got %h expected %h", g1, e);
            end
            g2 = got_q.pop_front();
            e  = exp_q.pop_front();
            checks++;
            if (g2 !== e) begin
                failures++;
                $display("FAIL b2b_frame2: got %h expected %h", g2, e);
            end
            checks++;
            if (g2.cyc - g1.cyc !== 32'd42) begin
                failures++;
                $display("FAIL b2b_spacing: %0d cycles, expected 42", g2.cyc - g1.cyc);
            end
        end
        checks++;
        if (low_cnt !== 1) begin
            failures++;
            $display("FAIL b2b_busy_gap: busy low %0d cycles, expected 1", low_cnt);
        end
    endtask

    task automatic test_reset_mid;
        rec_t g, e;
        logic [41:0] f;
        f = build(11'h2B4, 4'h6, 8'h99, crc_ref({11'h2B4, 4'h6, 8'h99}), 1'b1, 1'b1);
        for (int i = 41; i >= 22; i--) begin
            @(negedge clk);
            bus.rx = f[i];
        end
        @(negedge clk);
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.frame_valid, bus.rx_id, bus.rx_dlc, bus.rx_data, bus.rx_crc, bus.crc_err, bus.form_err} !== 42'd0) begin
            failures++;
            $display("FAIL midreset_outputs: busy=%b fv=%b id=%h dlc=%h data=%h crc=%h, expected all 0",
                     bus.busy, bus.frame_valid, bus.rx_id, bus.rx_dlc, bus.rx_data, bus.rx_crc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        checks++;
        if (got_q.size() !== 0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abort: frames=%0d busy=%b, expected 0 0", got_q.size(), bus.busy);
            got_q.delete();
        end
        send_frame(11'h2B4, 4'h6, 8'h99, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        bus.rx = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (got_q.size() == 0) begin
            failures++;
            $display("FAIL midreset_next: no frame seen, expected %h", e);
        end else begin
            g = got_q.pop_front();
            if (g !== e) begin
                failures++;
                $display("FAIL midreset_next: got %h expected %h", g, e);
            end
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset;
        test_idle;
        test_all_zero;
        test_crc;
        test_form;
        test_back_to_back;
        test_reset_mid;
        repeat (5) @(negedge clk);
        checks++;
        if (got_q.size() !== 0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL leftover: %0d unexpected frames, %0d unmatched expectations, expected 0 0", got_q.size(), exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
